// File: rtl/div_sequencer_if.sv
// div_sequencer_if: operand/result valid-ready bus between producer, divider and consumer
interface div_sequencer_if #(parameter int W = 4);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider, one quotient bit per clock
module div_sequencer #(
    parameter int W = 4
) (
    input logic           clk,
    input logic           rst_n,
    div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(W);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t       r_state, w_next;
    logic [W-1:0] r_a, r_b, r_rem, r_q;
    logic [CNT_W-1:0] r_cnt;
    logic         r_dbz;
    logic         w_in_ready, w_out_valid;
    logic [W:0]   w_t, w_d;
    assign w_t = {r_rem, r_a[W-1]};
    assign w_d = w_t - {1'b0, r_b};
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = (bus.divisor == '0) ? DONE : CALC;
            end
            CALC: w_next = (r_cnt == '0) ? DONE : CALC;
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Partial remainder stays below b, so W bits suffice; the borrow lives only in w_d[W]
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a   <= bus.dividend;
                    r_b   <= bus.divisor;
                    r_cnt <= CNT_W'(W - 1);
                    r_q   <= (bus.divisor == '0) ? '1 : '0;
                    r_rem <= (bus.divisor == '0) ? bus.dividend : '0;
                    r_dbz <= (bus.divisor == '0);
                end
                CALC: begin
                    r_a   <= r_a << 1;
                    r_rem <= w_d[W] ? w_t[W-1:0] : w_d[W-1:0];
                    r_q   <= {r_q[W-2:0], ~w_d[W]};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                DONE: if (bus.out_ready) r_dbz <= 1'b0;
                default: ;
            endcase
        end
    end
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.busy        = (r_state != IDLE);
    assign bus.quotient    = r_q;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule
